// File: rtl/desc_dbuf_loader.sv
// Double-buffered descriptor loader: pixels stream into a shadow register that the matcher swaps into the active one.
// Optional mean/variance accumulators are built when DESC_STATS_EN is defined.
module desc_dbuf_loader #(
    parameter int PIXEL_W    = 8,
    parameter int NUM_PIXELS = 256,
    parameter int DESC_W     = PIXEL_W * NUM_PIXELS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [PIXEL_W-1:0] in_data,
    output logic               in_ready,
    output logic               load_done,
    output logic               shadow_full,
    input  logic               swap,
    output logic               desc_valid,
    output logic [DESC_W-1:0]  desc_out,
    output logic               busy
`ifdef DESC_STATS_EN
    ,
    output logic [PIXEL_W+$clog2(NUM_PIXELS)-1:0]   desc_sum,
    output logic [2*PIXEL_W+$clog2(NUM_PIXELS)-1:0] desc_sumsq
`endif
);

    localparam int CNT_W = $clog2(NUM_PIXELS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [DESC_W-1:0] shadow;
    logic              beat;
    logic              last_beat;
    logic              do_swap;
    logic              shadow_clear;

    assign in_ready  = (state == LOAD) && !start;
    assign busy      = (state == LOAD);
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (count == LAST_IDX);
    assign do_swap   = (state == FULL) && swap;
    // A start in FULL only counts once the shadow has been handed over.
    assign shadow_clear = start && ((state == IDLE) || (state == LOAD) || do_swap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            shadow      <= '0;
            desc_out    <= '0;
            desc_valid  <= 1'b0;
            shadow_full <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            load_done <= last_beat;

            if (shadow_clear) begin
                count  <= '0;
                shadow <= '0;
            end else if (beat) begin
                shadow <= {shadow[DESC_W-PIXEL_W-1:0], in_data};
                count  <= last_beat ? '0 : count + CNT_W'(1);
            end

            if (do_swap) begin
                desc_out   <= shadow;
                desc_valid <= 1'b1;
            end

            if (last_beat)
                shadow_full <= 1'b1;
            else if (do_swap)
                shadow_full <= 1'b0;

            case (state)
                IDLE:    if (start) state <= LOAD;
                LOAD:    if (last_beat) state <= FULL;
                FULL:    if (swap) state <= start ? LOAD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DESC_STATS_EN
    localparam int SUM_W = PIXEL_W + CNT_W;
    localparam int SQ_W  = 2 * PIXEL_W + CNT_W;

    logic [SUM_W-1:0]     sum_acc;
    logic [SQ_W-1:0]      sq_acc;
    logic [2*PIXEL_W-1:0] pix_sq;

    assign pix_sq = {{PIXEL_W{1'b0}}, in_data} * {{PIXEL_W{1'b0}}, in_data};

    // Accumulators track the shadow buffer and travel with it on swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_acc    <= '0;
            sq_acc     <= '0;
            desc_sum   <= '0;
            desc_sumsq <= '0;
        end else begin
            if (shadow_clear) begin
                sum_acc <= '0;
                sq_acc  <= '0;
            end else if (beat) begin
                sum_acc <= sum_acc + {{CNT_W{1'b0}}, in_data};
                sq_acc  <= sq_acc + {{CNT_W{1'b0}}, pix_sq};
            end
            if (do_swap) begin
                desc_sum   <= sum_acc;
                desc_sumsq <= sq_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_desc_dbuf_loader.sv
// Self-checking bench for desc_dbuf_loader (PIXEL_W=8, NUM_PIXELS=4): queue-based reference model plus literal checks.
// Stats outputs are checked only when DESC_STATS_EN is defined.
module tb_desc_dbuf_loader;

    localparam int PW  = 8;
    localparam int NP  = 4;
    localparam int DW  = PW * NP;
    localparam int SUMW = PW + $clog2(NP);
    localparam int SQW  = 2 * PW + $clog2(NP);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          swap = 1'b0;
    logic          in_ready, load_done, shadow_full, desc_valid, busy;
    logic [DW-1:0] desc_out;
`ifdef DESC_STATS_EN
    logic [SUMW-1:0] desc_sum;
    logic [SQW-1:0]  desc_sumsq;
`endif

    int checks = 0;
    int errors = 0;

    desc_dbuf_loader #(.PIXEL_W(PW), .NUM_PIXELS(NP)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load_done(load_done), .shadow_full(shadow_full),
        .swap(swap), .desc_valid(desc_valid), .desc_out(desc_out), .busy(busy)
`ifdef DESC_STATS_EN
        , .desc_sum(desc_sum), .desc_sumsq(desc_sumsq)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: loading/full flags plus the list of pixels received so far.
    bit              m_loading, m_full, m_done, m_valid;
    logic [PW-1:0]   m_pix[$];
    logic [DW-1:0]   m_active;
    logic [SUMW-1:0] m_sum;
    logic [SQW-1:0]  m_sumsq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 0; m_full = 0; m_done = 0; m_valid = 0;
            m_pix.delete(); m_active = '0; m_sum = '0; m_sumsq = '0;
        end else begin
            m_done = 0;
            if (m_loading) begin
                if (start) m_pix.delete();
                else if (in_valid) begin
                    m_pix.push_back(in_data);
                    if (m_pix.size() == NP) begin
                        m_loading = 0; m_full = 1; m_done = 1;
                    end
                end
            end else if (m_full) begin
                if (swap) begin
                    m_active = '0; m_sum = '0; m_sumsq = '0;
                    foreach (m_pix[i]) begin
                        m_active = (m_active << PW) | DW'(m_pix[i]);
                        m_sum    = m_sum + SUMW'(m_pix[i]);
                        m_sumsq  = m_sumsq + SQW'(int'(m_pix[i]) * int'(m_pix[i]));
                    end
                    m_valid = 1; m_full = 0;
                    if (start) begin m_loading = 1; m_pix.delete(); end
                end
            end else if (start) begin
                m_loading = 1; m_pix.delete();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("in_ready", 64'(in_ready), 64'(m_loading && !start));
        checkOutput("busy", 64'(busy), 64'(m_loading));
        checkOutput("load_done", 64'(load_done), 64'(m_done));
        checkOutput("shadow_full", 64'(shadow_full), 64'(m_full));
        checkOutput("desc_valid", 64'(desc_valid), 64'(m_valid));
        checkOutput("desc_out", 64'(desc_out), 64'(m_active));
`ifdef DESC_STATS_EN
        checkOutput("desc_sum", 64'(desc_sum), 64'(m_sum));
        checkOutput("desc_sumsq", 64'(desc_sumsq), 64'(m_sumsq));
`endif
    end

    task automatic applyStimulus(input logic st, input logic v, input logic [PW-1:0] d, input logic sw);
        start = st; in_valid = v; in_data = d; swap = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic loadFour(input logic [DW-1:0] word);
        applyStimulus(1, 0, 0, 0);
        for (int i = NP - 1; i >= 0; i--) applyStimulus(0, 1, word[i*PW +: PW], 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset desc_out", 64'(desc_out), 64'h0);
        checkOutput("reset desc_valid", 64'(desc_valid), 64'h0);
        rst = 1'b0;

        // Straight load then swap
        loadFour(32'h11223344);
        checkOutput("t1 load_done", 64'(load_done), 64'h1);
        checkOutput("t1 shadow_full", 64'(shadow_full), 64'h1);
        checkOutput("t1 in_ready", 64'(in_ready), 64'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1 desc_out", 64'(desc_out), 64'h11223344);
        checkOutput("t1 shadow_full after swap", 64'(shadow_full), 64'h0);
        checkOutput("t1 busy", 64'(busy), 64'h0);
        applyStimulus(0, 0, 0, 0);

        // Gapped load, extra beats offered while full
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 8'h11, 0); applyStimulus(0, 0, 8'hEE, 0);
        applyStimulus(0, 1, 8'h22, 0); applyStimulus(0, 0, 8'hEE, 0);
        applyStimulus(0, 1, 8'h33, 0); applyStimulus(0, 0, 8'hEE, 0);
        applyStimulus(0, 1, 8'h44, 0);
        applyStimulus(0, 1, 8'h99, 0);
        checkOutput("t2 in_ready full", 64'(in_ready), 64'h0);
        applyStimulus(1, 1, 8'h98, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2 desc_out", 64'(desc_out), 64'h11223344);
        applyStimulus(0, 0, 0, 0);

        // Restart mid-load
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 8'hAA, 0);
        applyStimulus(0, 1, 8'hBB, 0);
        applyStimulus(1, 1, 8'hCC, 0);
        applyStimulus(0, 1, 8'h01, 0);
        applyStimulus(0, 1, 8'h02, 0);
        applyStimulus(0, 1, 8'h03, 0);
        checkOutput("t3 no early load_done", 64'(load_done), 64'h0);
        applyStimulus(0, 1, 8'h04, 0);
        checkOutput("t3 load_done", 64'(load_done), 64'h1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t3 desc_out", 64'(desc_out), 64'h01020304);
        applyStimulus(0, 0, 0, 0);

        // Asynchronous reset in the middle of a second load
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 8'h55, 0);
        applyStimulus(0, 1, 8'h66, 0);
        start = 0; in_valid = 0; swap = 0;
        #2 rst = 1'b1;
        #1;
        checkOutput("t4 desc_out", 64'(desc_out), 64'h0);
        checkOutput("t4 desc_valid", 64'(desc_valid), 64'h0);
        checkOutput("t4 busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        loadFour(32'h11223344);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4 reload desc_out", 64'(desc_out), 64'h11223344);

        // Back-to-back: swap and start together
        loadFour(32'h05060708);
        applyStimulus(1, 0, 0, 1);
        start = 0; swap = 0;
        #1;
        checkOutput("t5 desc_out", 64'(desc_out), 64'h05060708);
        checkOutput("t5 busy", 64'(busy), 64'h1);
        checkOutput("t5 in_ready", 64'(in_ready), 64'h1);
        applyStimulus(0, 1, 8'h09, 0);
        applyStimulus(0, 1, 8'h0A, 0);
        applyStimulus(0, 1, 8'h0B, 0);
        applyStimulus(0, 1, 8'h0C, 0);
        checkOutput("t5 second load_done", 64'(load_done), 64'h1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t5 second desc_out", 64'(desc_out), 64'h090A0B0C);
        applyStimulus(0, 0, 0, 0);

        // Statistics vector
        loadFour(32'h010203FF);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t6 desc_out", 64'(desc_out), 64'h010203FF);
`ifdef DESC_STATS_EN
        checkOutput("t6 desc_sum", 64'(desc_sum), 64'h105);
        checkOutput("t6 desc_sumsq", 64'(desc_sumsq), 64'd65039);
`endif
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/desc_dbuf_loader.md
Name: desc_dbuf_loader

Overview:
- Parametrised, double-buffered descriptor loader for the NCC matcher.
- Accepts pixels from the host/PCI byte stream over a valid/ready handshake and fills a shadow descriptor register.
- The matcher promotes the shadow register to the active register with a swap request, so descriptor N+1 loads while descriptor N is in use.
- Generalises pixel width and pixel count, adds backpressure, restart and done signalling, plus optional mean/variance statistics.

Parameters:
- PIXEL_W, 8, bits per pixel.
- NUM_PIXELS, 256, pixels per descriptor; must be >= 2.
- DESC_W, PIXEL_W*NUM_PIXELS, descriptor width in bits. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin (or restart) loading the shadow buffer.
- in_valid  in  1  in_data holds a pixel.
- in_data  in  PIXEL_W  pixel value.
- in_ready  out  1  loader accepts a pixel this cycle.
- load_done  out  1  one-cycle pulse: shadow buffer complete.
- shadow_full  out  1  shadow buffer holds a complete, unswapped descriptor.
- swap  in  1  request to promote shadow to active.
- desc_valid  out  1  active buffer holds a descriptor.
- desc_out  out  DESC_W  active descriptor.
- busy  out  1  state is LOAD.

Behaviour:
- Reset: state=IDLE, count=0, shadow=0, active=0. All outputs are 0 (in_ready, load_done, shadow_full, desc_valid, busy, desc_out, and the stats outputs when enabled). Reset asserted mid-load discards the partial descriptor.
- A beat is accepted when in_valid && in_ready, sampled on the rising clk edge.
- Packing: each accepted beat shifts shadow left by PIXEL_W and inserts in_data at bits [PIXEL_W-1:0]. The first pixel ends in the MSBs.
- Internal count has width $clog2(NUM_PIXELS) and counts accepted beats 0..NUM_PIXELS-1.
- in_ready = (state==LOAD) && !start; it is combinational from state and start.
- FSM:
  - IDLE: start -> LOAD; clear count and shadow. swap is ignored.
  - LOAD: each accepted beat increments count. If a beat is accepted with count==NUM_PIXELS-1, then next cycle: state=FULL, count=0, shadow_full=1, load_done=1 for exactly one cycle.
  - LOAD, start asserted: restart. Clear count and shadow; stay in LOAD; in_ready is 0 that cycle, so no beat is accepted.
  - FULL: in_ready=0. swap -> active<=shadow, desc_valid<=1, shadow_full<=0.
    - If start is also asserted: next state LOAD with count/shadow cleared (back-to-back load).
    - Otherwise: next state IDLE.
  - FULL, start without swap: ignored; the shadow is never overwritten before it is swapped.
- desc_out, desc_valid and the stats outputs change only on swap. They are stable while a new load is in progress.
- Latency: last beat accepted at edge k -> load_done/shadow_full high after edge k. swap sampled at edge j -> desc_out updated after edge j.
- busy = (state==LOAD), registered via state.

Optional Feature:
- Macro: DESC_STATS_EN.
- Defined:
  - Add output desc_sum, width PIXEL_W+$clog2(NUM_PIXELS).
  - Add output desc_sumsq, width 2*PIXEL_W+$clog2(NUM_PIXELS).
  - Shadow accumulators clear whenever the shadow clears. Each accepted beat adds in_data and in_data*in_data (unsigned, no overflow at max parameters).
  - Both accumulators copy to the outputs on swap, together with desc_out. Reset value 0.
- Not defined: the ports, accumulators and multiplier are absent; all other behaviour is identical.

Test Plan:
- PIXEL_W=8, NUM_PIXELS=4: start, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> load_done pulses once one cycle after the 0x44 beat, shadow_full=1, in_ready=0. swap -> desc_out=0x11223344, desc_valid=1, shadow_full=0, state IDLE.
- Same load with in_valid low on alternate cycles, plus extra beats offered while in FULL -> descriptor still 0x11223344; extra beats never accepted (in_ready=0).
- start, beats 0xAA,0xBB, start again, beats 0x01..0x04 -> after swap desc_out=0x01020304; no load_done before the 4th post-restart beat.
- Descriptor A loaded and swapped, then a second load in progress: assert rst after the 2nd beat -> all outputs 0 immediately (asynchronous), desc_valid=0, state IDLE. A subsequent full load works normally.
- Shadow full with 0x05060708 and active=0x11223344: assert start and swap in the same cycle -> desc_out=0x05060708 next cycle, busy=1, in_ready=1; four new beats produce a second load_done.
- DESC_STATS_EN defined: beats 0x01,0x02,0x03,0xFF then swap -> desc_sum=0x105, desc_sumsq=65039. Without the macro, the same stimulus compiles and the bench checks only desc_out.
